tlb_access_scheduler: RTL
=========================

TLB_ACCESS_SCHEDULER -- requirements
Module: tlb_access_scheduler

Interface
REQ-001 SHALL have parameter ENTRY_NUM, default 32, TLB entry count (power of two, >=2); IW = log2(ENTRY_NUM).
REQ-002 SHALL have port clk  in  1  sole clock, rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-004 SHALL have ports if_req_valid/lsu_req_valid  in  1  fetch / load-store search request.
REQ-005 SHALL have ports if_req_vpn/lsu_req_vpn  in  20  VA[31:12]; if_req_asid/lsu_req_asid  in  10  ASID.
REQ-006 SHALL have ports if_req_ready/lsu_req_ready  out  1  request granted this cycle.
REQ-007 SHALL have ports if_rsp_valid/lsu_rsp_valid  out  1  shared TLB search response belongs to this requester.
REQ-008 SHALL have ports priv_valid  in  1, priv_op  in  3 (0 SRCH, 1 RD, 2 WR, 3 FILL, 4 INV, 5-7 illegal), priv_idx  in  IW, priv_vpn  in  20, priv_asid  in  10.
REQ-009 SHALL have ports priv_ready  out  1  op accepted; priv_done  out  1  one-cycle completion pulse; priv_fill_idx  out  IW  index used by last FILL.
REQ-010 SHALL have TLB-side ports srch_valid  out  1, srch_vpn  out  20, srch_asid  out  10, rd_valid  out  1, rd_idx  out  IW, wr_valid  out  1, wr_idx  out  IW, inv_valid  out  1.
REQ-011 SHALL NOT carry write-entry or invalidate payload; those wire directly from the privileged unit to the TLB.

Function
REQ-012 SHALL implement FSM states IDLE, ISSUE, WAIT; one-hot or encoded at implementer's choice.
REQ-013 IDLE: priv_ready=1; priv_valid -> latch op/idx/vpn/asid, go ISSUE; if_req_ready=lsu_req_ready=0 that cycle.
REQ-014 IDLE, priv_valid=0: grant at most one of IF/LSU per cycle; drive srch_valid=1 with granted vpn/asid (combinational).
REQ-015 Both IF and LSU valid: grant the one not granted most recently (round-robin pointer); single requester always granted.
REQ-016 Round-robin pointer SHALL update only on a grant.
REQ-017 ISSUE: exactly one strobe per latched op: SRCH->srch_valid with latched vpn/asid; RD->rd_valid, rd_idx=latched idx; WR->wr_valid, wr_idx=latched idx; FILL->wr_valid, wr_idx=fill counter; INV->inv_valid; illegal->no strobe; next state WAIT.
REQ-018 WAIT: no strobes, no grants, priv_done=1, next state IDLE; total priv latency 2 cycles accept-to-done.
REQ-019 priv_ready SHALL be 0 in ISSUE and WAIT; IF/LSU ready SHALL be 0 in ISSUE and WAIT.
REQ-020 if_rsp_valid/lsu_rsp_valid SHALL be registered copies of the respective grant (1 cycle after grant).
REQ-021 Fill counter: IW-bit, increments every cycle, wraps ENTRY_NUM-1 -> 0; priv_fill_idx registers its value at FILL ISSUE.
REQ-022 Back-to-back priv ops: next accepted no earlier than the cycle after WAIT (priv throughput one per 3 cycles).
REQ-023 Search granted in cycle N followed by priv accept in N+1: response still flagged in N+1 via REQ-020.

Reset
REQ-024 rst_n=0 at a clock edge SHALL force IDLE, round-robin pointer to favour IF, fill counter 0, priv_fill_idx 0, all rsp_valid/done/strobe outputs 0.
REQ-025 Reset asserted during ISSUE or WAIT SHALL abort: no priv_done, no strobe after the reset edge.

Verification
REQ-026 IF and LSU valid continuously 4 cycles from reset -> grants IF, LSU, IF, LSU; rsp_valid one cycle later each.
REQ-027 priv RD idx=5 while IF valid -> accept cycle: if_req_ready=0; next cycle rd_valid=1, rd_idx=5; following cycle priv_done=1; IF granted cycle after.
REQ-028 priv FILL accepted 7 cycles after reset (ENTRY_NUM=32) -> ISSUE cycle wr_idx=8, priv_fill_idx=8 afterwards; counter wraps 31->0 at cycle 32.
REQ-029 priv_op=6 -> no strobe in ISSUE, priv_done=1 in WAIT.
REQ-030 rst_n=0 during WAIT of WR op -> priv_done stays 0, state IDLE, priv_ready=1 first cycle after reset release.

Source files
------------

// File: rtl/tlb_access_scheduler_if.sv
// Request/response bundle between the IF/LSU requesters, the privileged unit and the TLB.
// The slave modport is the scheduler's view; master is the environment driving it.
interface tlb_access_scheduler_if #(
    parameter int ENTRY_NUM = 32
) ();
    localparam int IW = $clog2(ENTRY_NUM);

    logic          if_req_valid;
    logic [19:0]   if_req_vpn;
    logic [9:0]    if_req_asid;
    logic          if_req_ready;
    logic          if_rsp_valid;

    logic          lsu_req_valid;
    logic [19:0]   lsu_req_vpn;
    logic [9:0]    lsu_req_asid;
    logic          lsu_req_ready;
    logic          lsu_rsp_valid;

    logic          priv_valid;
    logic [2:0]    priv_op;
    logic [IW-1:0] priv_idx;
    logic [19:0]   priv_vpn;
    logic [9:0]    priv_asid;
    logic          priv_ready;
    logic          priv_done;
    logic [IW-1:0] priv_fill_idx;

    logic          srch_valid;
    logic [19:0]   srch_vpn;
    logic [9:0]    srch_asid;
    logic          rd_valid;
    logic [IW-1:0] rd_idx;
    logic          wr_valid;
    logic [IW-1:0] wr_idx;
    logic          inv_valid;

    modport slave (
        input  if_req_valid, if_req_vpn, if_req_asid,
        input  lsu_req_valid, lsu_req_vpn, lsu_req_asid,
        input  priv_valid, priv_op, priv_idx, priv_vpn, priv_asid,
        output if_req_ready, if_rsp_valid, lsu_req_ready, lsu_rsp_valid,
        output priv_ready, priv_done, priv_fill_idx,
        output srch_valid, srch_vpn, srch_asid, rd_valid, rd_idx,
        output wr_valid, wr_idx, inv_valid
    );

    modport master (
        output if_req_valid, if_req_vpn, if_req_asid,
        output lsu_req_valid, lsu_req_vpn, lsu_req_asid,
        output priv_valid, priv_op, priv_idx, priv_vpn, priv_asid,
        input  if_req_ready, if_rsp_valid, lsu_req_ready, lsu_rsp_valid,
        input  priv_ready, priv_done, priv_fill_idx,
        input  srch_valid, srch_vpn, srch_asid, rd_valid, rd_idx,
        input  wr_valid, wr_idx, inv_valid
    );
endinterface

// File: rtl/tlb_access_scheduler.sv
// Shares one TLB between round-robin IF/LSU searches and privileged ops
// (search/read/write/fill/invalidate), which pre-empt searches for three cycles.
module tlb_access_scheduler #(
    parameter int ENTRY_NUM = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    tlb_access_scheduler_if.slave        bus
);
    localparam int IW = $clog2(ENTRY_NUM);

    localparam logic [2:0] OP_SRCH = 3'd0;
    localparam logic [2:0] OP_RD   = 3'd1;
    localparam logic [2:0] OP_WR   = 3'd2;
    localparam logic [2:0] OP_FILL = 3'd3;
    localparam logic [2:0] OP_INV  = 3'd4;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;

    state_e        state_q, state_d;
    logic [2:0]    op_q;
    logic [IW-1:0] idx_q;
    logic [19:0]   vpn_q;
    logic [9:0]    asid_q;
    logic          preferIf_q;
    logic [IW-1:0] fillCnt_q;
    logic [IW-1:0] fillIdx_q;
    logic          ifRsp_q, lsuRsp_q;
    logic          ifGrant, lsuGrant;
    logic          privAccept;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.priv_valid) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A privileged request in IDLE wins outright; otherwise searches share the TLB round-robin.
    always_comb begin
        bus.priv_ready = 1'b0;
        bus.priv_done  = 1'b0;
        bus.srch_valid = 1'b0;
        bus.srch_vpn   = '0;
        bus.srch_asid  = '0;
        bus.rd_valid   = 1'b0;
        bus.rd_idx     = '0;
        bus.wr_valid   = 1'b0;
        bus.wr_idx     = '0;
        bus.inv_valid  = 1'b0;
        ifGrant        = 1'b0;
        lsuGrant       = 1'b0;
        case (state_q)
            IDLE: begin
                bus.priv_ready = 1'b1;
                if (!bus.priv_valid) begin
                    if (bus.if_req_valid && (!bus.lsu_req_valid || preferIf_q)) begin
                        ifGrant       = 1'b1;
                        bus.srch_vpn  = bus.if_req_vpn;
                        bus.srch_asid = bus.if_req_asid;
                    end else if (bus.lsu_req_valid) begin
                        lsuGrant      = 1'b1;
                        bus.srch_vpn  = bus.lsu_req_vpn;
                        bus.srch_asid = bus.lsu_req_asid;
                    end
                    bus.srch_valid = ifGrant | lsuGrant;
                end
            end
            ISSUE: begin
                case (op_q)
                    OP_SRCH: begin
                        bus.srch_valid = 1'b1;
                        bus.srch_vpn   = vpn_q;
                        bus.srch_asid  = asid_q;
                    end
                    OP_RD: begin
                        bus.rd_valid = 1'b1;
                        bus.rd_idx   = idx_q;
                    end
                    OP_WR: begin
                        bus.wr_valid = 1'b1;
                        bus.wr_idx   = idx_q;
                    end
                    OP_FILL: begin
                        bus.wr_valid = 1'b1;
                        bus.wr_idx   = fillCnt_q;
                    end
                    OP_INV:  bus.inv_valid = 1'b1;
                    default: ;
                endcase
            end
            WAIT:    bus.priv_done = 1'b1;
            default: ;
        endcase
    end

    assign privAccept        = (state_q == IDLE) && bus.priv_valid;
    assign bus.if_req_ready  = ifGrant;
    assign bus.lsu_req_ready = lsuGrant;
    assign bus.if_rsp_valid  = ifRsp_q;
    assign bus.lsu_rsp_valid = lsuRsp_q;
    assign bus.priv_fill_idx = fillIdx_q;

    // The free-running fill counter gives FILL a pseudo-random victim index.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q       <= '0;
            idx_q      <= '0;
            vpn_q      <= '0;
            asid_q     <= '0;
            preferIf_q <= 1'b1;
            fillCnt_q  <= '0;
            fillIdx_q  <= '0;
            ifRsp_q    <= 1'b0;
            lsuRsp_q   <= 1'b0;
        end else begin
            fillCnt_q <= fillCnt_q + IW'(1);
            ifRsp_q   <= ifGrant;
            lsuRsp_q  <= lsuGrant;
            if (ifGrant)       preferIf_q <= 1'b0;
            else if (lsuGrant) preferIf_q <= 1'b1;
            if (privAccept) begin
                op_q   <= bus.priv_op;
                idx_q  <= bus.priv_idx;
                vpn_q  <= bus.priv_vpn;
                asid_q <= bus.priv_asid;
            end
            if (state_q == ISSUE && op_q == OP_FILL) fillIdx_q <= fillCnt_q;
        end
    end
endmodule
